// File: rtl/tft_spi_monitor_if.sv
// TFT SPI analyzer bus: sampled SPI pins plus the decoded byte/window/pixel stream.
// Optional pixel_x/pixel_y signals exist only when TFT_MON_COORD_EN is defined.
interface tft_spi_monitor_if;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_dc;
  logic        spi_cs;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic [15:0] col_start;
  logic [15:0] col_end;
  logic [15:0] row_start;
  logic [15:0] row_end;
  logic        frame_start;
  logic        pixel_valid;
  logic [15:0] pixel_data;
`ifdef TFT_MON_COORD_EN
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
`endif

  // Monitor side: samples the pins, drives the decoded stream.
  modport slave (
    input  spi_clk, spi_mosi, spi_dc, spi_cs,
    output byte_valid, byte_data, byte_dc,
    output col_start, col_end, row_start, row_end,
    output frame_start, pixel_valid, pixel_data
`ifdef TFT_MON_COORD_EN
    , output pixel_x, pixel_y
`endif
  );

  // Driver/consumer side.
  modport master (
    output spi_clk, spi_mosi, spi_dc, spi_cs,
    input  byte_valid, byte_data, byte_dc,
    input  col_start, col_end, row_start, row_end,
    input  frame_start, pixel_valid, pixel_data
`ifdef TFT_MON_COORD_EN
    , input pixel_x, pixel_y
`endif
  );
endinterface

// File: rtl/tft_spi_monitor.sv
// Passive TFT SPI monitor: oversamples the bus, rebuilds bytes and decodes CASET/PASET/RAMWR.
// Define TFT_MON_COORD_EN to add pixel_x/pixel_y coordinate tracking.
module tft_spi_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_CASET   = 8'h2A,
  parameter logic [7:0]  CMD_PASET   = 8'h2B,
  parameter logic [7:0]  CMD_RAMWR   = 8'h2C
) (
  input  logic clk,
  input  logic rst,
  tft_spi_monitor_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CASET_P, PASET_P, RAMWR_D, SKIP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, mosi_sync, dc_sync, cs_sync;
  logic clk_prev;
  logic clk_s, mosi_s, dc_s, cs_s, rise;

  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;

  state_t      state, state_d;
  logic [1:0]  idx, idx_d;
  logic [23:0] shadow, shadow_d;
  logic [7:0]  hi, hi_d;
  logic        have_hi, have_hi_d;
  logic [15:0] col_start, col_start_d, col_end, col_end_d;
  logic [15:0] row_start, row_start_d, row_end, row_end_d;
  logic        frame_start, frame_start_d;
  logic        pixel_valid, pixel_valid_d;
  logic [15:0] pixel_data, pixel_data_d;
`ifdef TFT_MON_COORD_EN
  logic [15:0] x_cnt, x_cnt_d, y_cnt, y_cnt_d;
  logic [15:0] pixel_x, pixel_x_d, pixel_y, pixel_y_d;
`endif

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign rise   = clk_s & ~clk_prev;

  // Input synchronizers; cs idles deasserted out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_sync   <= '1;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], bus.spi_dc};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
      clk_prev  <= clk_s;
    end
  end

  // Bit assembly; a deasserted cs drops any partial byte and masks a coincident edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (rise) begin
        shreg   <= {shreg[5:0], mosi_s};
        bit_cnt <= 3'(bit_cnt + 3'd1);
        if (bit_cnt == 3'd7) begin
          byte_data  <= {shreg, mosi_s};
          byte_dc    <= dc_s;
          byte_valid <= 1'b1;
        end
      end
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      shadow      <= '0;
      hi          <= '0;
      have_hi     <= 1'b0;
      col_start   <= '0;
      col_end     <= '0;
      row_start   <= '0;
      row_end     <= '0;
      frame_start <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
`ifdef TFT_MON_COORD_EN
      x_cnt       <= '0;
      y_cnt       <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
`endif
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      shadow      <= shadow_d;
      hi          <= hi_d;
      have_hi     <= have_hi_d;
      col_start   <= col_start_d;
      col_end     <= col_end_d;
      row_start   <= row_start_d;
      row_end     <= row_end_d;
      frame_start <= frame_start_d;
      pixel_valid <= pixel_valid_d;
      pixel_data  <= pixel_data_d;
`ifdef TFT_MON_COORD_EN
      x_cnt       <= x_cnt_d;
      y_cnt       <= y_cnt_d;
      pixel_x     <= pixel_x_d;
      pixel_y     <= pixel_y_d;
`endif
    end
  end

  // Next-state: commands always re-enter the FSM; data bytes are interpreted per state.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    shadow_d      = shadow;
    hi_d          = hi;
    have_hi_d     = have_hi;
    col_start_d   = col_start;
    col_end_d     = col_end;
    row_start_d   = row_start;
    row_end_d     = row_end;
    frame_start_d = 1'b0;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data;
`ifdef TFT_MON_COORD_EN
    x_cnt_d       = x_cnt;
    y_cnt_d       = y_cnt;
    pixel_x_d     = pixel_x;
    pixel_y_d     = pixel_y;
`endif
    if (byte_valid) begin
      if (!byte_dc) begin
        idx_d     = '0;
        have_hi_d = 1'b0;
        if (byte_data == CMD_CASET) begin
          state_d = CASET_P;
        end else if (byte_data == CMD_PASET) begin
          state_d = PASET_P;
        end else if (byte_data == CMD_RAMWR) begin
          state_d       = RAMWR_D;
          frame_start_d = 1'b1;
`ifdef TFT_MON_COORD_EN
          x_cnt_d = col_start;
          y_cnt_d = row_start;
`endif
        end else begin
          state_d = SKIP;
        end
      end else begin
        case (state)
          CASET_P, PASET_P: begin
            shadow_d = {shadow[15:0], byte_data};
            idx_d    = 2'(idx + 2'd1);
            if (idx == 2'd3) begin
              state_d = SKIP;
              if (state == CASET_P) begin
                col_start_d = shadow[23:8];
                col_end_d   = {shadow[7:0], byte_data};
              end else begin
                row_start_d = shadow[23:8];
                row_end_d   = {shadow[7:0], byte_data};
              end
            end
          end
          RAMWR_D: begin
            if (!have_hi) begin
              hi_d      = byte_data;
              have_hi_d = 1'b1;
            end else begin
              have_hi_d     = 1'b0;
              pixel_valid_d = 1'b1;
              pixel_data_d  = {hi, byte_data};
`ifdef TFT_MON_COORD_EN
              pixel_x_d = x_cnt;
              pixel_y_d = y_cnt;
              if (x_cnt == col_end) begin
                x_cnt_d = col_start;
                y_cnt_d = (y_cnt == row_end) ? row_start : 16'(y_cnt + 16'd1);
              end else begin
                x_cnt_d = 16'(x_cnt + 16'd1);
              end
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_valid  = byte_valid;
  assign bus.byte_data   = byte_data;
  assign bus.byte_dc     = byte_dc;
  assign bus.col_start   = col_start;
  assign bus.col_end     = col_end;
  assign bus.row_start   = row_start;
  assign bus.row_end     = row_end;
  assign bus.frame_start = frame_start;
  assign bus.pixel_valid = pixel_valid;
  assign bus.pixel_data  = pixel_data;
`ifdef TFT_MON_COORD_EN
  assign bus.pixel_x     = pixel_x;
  assign bus.pixel_y     = pixel_y;
`endif

endmodule

// File: tb/tb_tft_spi_monitor.sv
// Directed bench for tft_spi_monitor; coordinate checks compile in with TFT_MON_COORD_EN.
module tb_tft_spi_monitor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tft_spi_monitor_if ifc ();
  tft_spi_monitor dut (.clk(clk), .rst(rst), .bus(ifc));

  int pass_cnt = 0;
  int total = 0;
  int bv_cnt = 0, fs_cnt = 0, pn = 0;
  logic [15:0] pd [32];
  logic [15:0] px [32];
  logic [15:0] py [32];

  // Pulse counters and pixel capture, sampled away from the active edge.
  always @(negedge clk) begin
    if (ifc.byte_valid)  bv_cnt <= bv_cnt + 1;
    if (ifc.frame_start) fs_cnt <= fs_cnt + 1;
    if (ifc.pixel_valid && pn < 32) begin
      pd[pn] <= ifc.pixel_data;
`ifdef TFT_MON_COORD_EN
      px[pn] <= ifc.pixel_x;
      py[pn] <= ifc.pixel_y;
`else
      px[pn] <= '0;
      py[pn] <= '0;
`endif
      pn <= pn + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic spi_bits(input logic [7:0] b, input logic dc, input int n);
    for (int i = 0; i < n; i++) begin
      ifc.spi_mosi = b[7-i];
      ifc.spi_dc   = dc;
      ifc.spi_clk  = 1'b0;
      repeat (4) @(negedge clk);
      ifc.spi_clk  = 1'b1;
      repeat (4) @(negedge clk);
    end
    ifc.spi_clk = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic dc);
    ifc.spi_cs = 1'b0;
    spi_bits(b, dc, 8);
    repeat (4) @(negedge clk);
  endtask

  int b0, f0, p0;
  logic [63:0] win;

  initial begin
    rst = 1'b0;
    ifc.spi_clk = 1'b0; ifc.spi_mosi = 1'b0; ifc.spi_dc = 1'b0; ifc.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ifc.byte_valid, ifc.byte_data, ifc.byte_dc, ifc.frame_start,
                          ifc.pixel_valid, ifc.pixel_data}, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Load a window and a byte so reset has something to clear.
    send(8'h2A, 1'b0); send(8'h00, 1'b1); send(8'h01, 1'b1); send(8'h00, 1'b1); send(8'h01, 1'b1);
    chk("pre_reset_col", {ifc.col_start, ifc.col_end}, {16'd1, 16'd1});
    ifc.spi_cs = 1'b0;
    spi_bits(8'hF0, 1'b1, 4);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_byte_reset_out", {ifc.byte_valid, ifc.byte_data, ifc.byte_dc, ifc.frame_start,
                               ifc.pixel_valid, ifc.pixel_data}, 64'd0);
    chk("mid_byte_reset_win", {ifc.col_start, ifc.col_end, ifc.row_start, ifc.row_end}, 64'd0);
    ifc.spi_cs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    b0 = bv_cnt;
    send(8'hA5, 1'b1);
    chk("post_reset_bv_cnt", 64'(bv_cnt - b0), 64'd1);
    chk("post_reset_byte", {ifc.byte_data, ifc.byte_dc}, {8'hA5, 1'b1});

    // CASET commits only on the fourth parameter byte.
    send(8'h2A, 1'b0); send(8'h00, 1'b1); send(8'h10, 1'b1); send(8'h00, 1'b1);
    chk("caset_before_commit", {ifc.col_start, ifc.col_end}, 64'd0);
    send(8'h13, 1'b1);
    chk("caset_commit", {ifc.col_start, ifc.col_end}, {16'd16, 16'd19});
    send(8'h2B, 1'b0); send(8'h00, 1'b1); send(8'h05, 1'b1); send(8'h01, 1'b1); send(8'h3F, 1'b1);
    chk("paset_commit", {ifc.row_start, ifc.row_end}, {16'd5, 16'd319});
    send(8'h77, 1'b1);
    chk("extra_data_ignored", {ifc.col_start, ifc.col_end, ifc.row_start, ifc.row_end},
        {16'd16, 16'd19, 16'd5, 16'd319});

    // Aborted CASET, then a complete PASET.
    send(8'h2A, 1'b0); send(8'h00, 1'b1); send(8'h20, 1'b1);
    send(8'h2B, 1'b0);
    chk("abort_col_kept", {ifc.col_start, ifc.col_end}, {16'd16, 16'd19});
    send(8'h00, 1'b1); send(8'h01, 1'b1); send(8'h00, 1'b1); send(8'h02, 1'b1);
    chk("abort_then_rows", {ifc.col_start, ifc.col_end, ifc.row_start, ifc.row_end},
        {16'd16, 16'd19, 16'd1, 16'd2});

    // RAMWR over a 2x2 window.
    send(8'h2A, 1'b0); send(8'h00, 1'b1); send(8'h02, 1'b1); send(8'h00, 1'b1); send(8'h03, 1'b1);
    send(8'h2B, 1'b0); send(8'h00, 1'b1); send(8'h07, 1'b1); send(8'h00, 1'b1); send(8'h08, 1'b1);
    f0 = fs_cnt; p0 = pn;
    send(8'h2C, 1'b0);
    send(8'hF8, 1'b1); send(8'h00, 1'b1); send(8'h07, 1'b1); send(8'hE0, 1'b1);
    send(8'h00, 1'b1); send(8'h1F, 1'b1); send(8'hFF, 1'b1); send(8'hFF, 1'b1);
    send(8'h12, 1'b1); send(8'h34, 1'b1);
    chk("ramwr_frame_start", 64'(fs_cnt - f0), 64'd1);
    chk("ramwr_pixel_cnt", 64'(pn - p0), 64'd5);
    chk("ramwr_pix_0_1", {pd[p0], pd[p0+1]}, {16'hF800, 16'h07E0});
    chk("ramwr_pix_2_4", {pd[p0+2], pd[p0+3], pd[p0+4]}, {16'h001F, 16'hFFFF, 16'h1234});
`ifdef TFT_MON_COORD_EN
    chk("coord_0_1", {px[p0], py[p0], px[p0+1], py[p0+1]}, {16'd2, 16'd7, 16'd3, 16'd7});
    chk("coord_2_3", {px[p0+2], py[p0+2], px[p0+3], py[p0+3]}, {16'd2, 16'd8, 16'd3, 16'd8});
    chk("coord_4_wrap", {px[p0+4], py[p0+4]}, {16'd2, 16'd7});
`endif

    // cs glitch drops a partial byte.
    b0 = bv_cnt;
    ifc.spi_cs = 1'b0;
    spi_bits(8'hFF, 1'b1, 5);
    ifc.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h3C, 1'b1);
    chk("cs_glitch_bv_cnt", 64'(bv_cnt - b0), 64'd1);
    chk("cs_glitch_byte", {56'd0, ifc.byte_data}, 64'h3C);

    // Unknown opcode, unpaired RAMWR byte, trailing NOP.
    win = {ifc.col_start, ifc.col_end, ifc.row_start, ifc.row_end};
    f0 = fs_cnt; p0 = pn;
    send(8'h36, 1'b0); send(8'h48, 1'b1);
    send(8'h2C, 1'b0); send(8'hAB, 1'b1);
    send(8'h00, 1'b0);
    chk("odd_window_kept", {ifc.col_start, ifc.col_end, ifc.row_start, ifc.row_end},
        {16'd2, 16'd3, 16'd7, 16'd8});
    chk("odd_window_same", {ifc.col_start, ifc.col_end, ifc.row_start, ifc.row_end}, win);
    chk("odd_frame_start", 64'(fs_cnt - f0), 64'd1);
    chk("odd_no_pixel", 64'(pn - p0), 64'd0);
    ifc.spi_cs = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/tft_spi_monitor.md
Name: tft_spi_monitor

Overview:
- Receive-side counterpart of tft_spi: passively samples the 4-wire TFT SPI bus (clk/mosi/dc/cs) on the analyzer pins and reassembles bytes.
- Decodes the display command stream (CASET 0x2A, PASET 0x2B, RAMWR 0x2C) into window registers and an RGB565 pixel stream.
- Used for on-chip self-check of the init/scene/player drivers and as a bench scoreboard source.
- Runs entirely in the system clk domain, oversampling the SPI lines.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer chain (minimum 2).
- CMD_CASET, 8'h2A, column address set opcode.
- CMD_PASET, 8'h2B, page (row) address set opcode.
- CMD_RAMWR, 8'h2C, memory write opcode.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active low.
- spi_clk  in  1  SPI clock; async; data sampled on its rising edge (mode 0).
- spi_mosi  in  1  serial data, MSB first.
- spi_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 7 (last bit) of each byte.
- spi_cs  in  1  chip select, active low.
- byte_valid  out  1  one-cycle pulse per received byte.
- byte_data  out  8  last received byte.
- byte_dc  out  1  dc of last received byte.
- col_start, col_end  out  16 each  CASET window.
- row_start, row_end  out  16 each  PASET window.
- frame_start  out  1  one-cycle pulse on RAMWR command byte.
- pixel_valid  out  1  one-cycle pulse per complete pixel.
- pixel_data  out  16  RGB565 pixel, first byte is [15:8].
- pixel_x, pixel_y  out  16 each  coordinates of pixel_data; present only with TFT_MON_COORD_EN.

Behaviour:
- Reset (rst low, async): all outputs, window registers, counters and the FSM go to 0 / IDLE. Sync chains reset to 0, with spi_cs chain reset to 1.
- Input sampling:
  - All four inputs pass through SYNC_STAGES flops; an edge register detects spi_clk rising (sync & ~prev).
  - spi_clk high and low phases must each be ≥ SYNC_STAGES+1 clk cycles; faster clocks are unsupported and not detected.
- Bit assembly:
  - On each detected rising edge with synced cs = 0, shift mosi into an 8-bit register and increment a 3-bit counter.
  - On the 8th bit: register byte_data/byte_dc, pulse byte_valid, counter wraps to 0.
  - Latency from the 8th pin rising edge to byte_valid high is SYNC_STAGES+1 clk cycles.
  - Synced cs = 1 clears the bit counter immediately; a partial byte is discarded with no pulse.
- Decoder FSM (advances only on byte_valid):
  - IDLE, CASET_P, PASET_P, RAMWR_D, SKIP.
  - A command byte (dc = 0) in any state exits that state. CASET→CASET_P, PASET→PASET_P, RAMWR→RAMWR_D with frame_start pulsed, any other opcode→SKIP. Parameter index is cleared.
  - CASET_P / PASET_P:
    - Data bytes 0..3 are start_hi, start_lo, end_hi, end_lo into a shadow register.
    - After byte 3, shadow is committed atomically to start/end; FSM → SKIP. Extra data bytes are ignored.
    - A command arriving before byte 3 aborts the parameter set; window registers are unchanged.
  - RAMWR_D: data bytes alternate hi/lo. On the lo byte, pixel_valid pulses the same cycle pixel_data updates, one cycle after that byte's byte_valid. An unpaired hi byte left when a command arrives is discarded.
  - SKIP / IDLE: data bytes produce byte_valid only.
- cs deassertion does not change FSM state; the display controller keeps command context across cs toggles.
- Simultaneous events: rst has priority over everything. A cs rising in the same cycle as an spi_clk edge means that edge is ignored.

Optional Feature:
- Macro TFT_MON_COORD_EN.
- Defined:
  - pixel_x/pixel_y exist. frame_start loads x = col_start, y = row_start.
  - Each pixel_valid reports the current x/y, then advances: if x == col_end then x = col_start and y advances, else x + 1.
  - y advance: if y == row_end then y = row_start, else y + 1.
  - Equality compare only; if start > end, the counter runs through 16-bit wrap to reach end.
- Undefined: pixel_x/pixel_y ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst low mid-byte with spi activity → all outputs 0. After release, the next full byte 0xA5 dc = 1 → byte_valid once, byte_data = 0xA5, byte_dc = 1.
- CASET: cmd 0x2A, data 00 10 00 13 → col_start = 16, col_end = 19 only after the 4th data byte. PASET 00 05 01 3F → row_start = 5, row_end = 319.
- Abort: cmd 0x2A, data 00 20, then cmd 0x2B → col_start/col_end unchanged. FSM in PASET_P; next 4 bytes update rows.
- RAMWR with COORD_EN: window cols 2..3, rows 7..8. Cmd 0x2C, bytes F8 00 07 E0 00 1F FF FF 12 34 → frame_start once; 5 pixel_valid with data F800, 07E0, 001F, FFFF, 1234 at (2,7), (3,7), (2,8), (3,8), (2,7).
- cs glitch: 5 bits clocked, cs high 4 cycles, cs low, then full byte 0x3C → exactly one byte_valid, data 0x3C.
- Unknown/odd: cmd 0x36, data 0x48, then cmd 0x2C, data 0xAB, then cmd 0x00 → no window change, frame_start once, no pixel_valid.
